// File: rtl/conv_window_builder.sv
// Streaming 3x3 window generator: buffers two image rows and emits one packed
// 72-bit neighbourhood per pixel that completes a full 3x3 window.
module conv_window_builder #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        in_valid_i,
   input  logic [7:0]  in_pix_i,
   output logic        in_ready_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [71:0] window_o,
   output logic        win_last_o
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [7:0]            line1_q [IMG_W];
   logic [7:0]            line2_q [IMG_W];
   // arr[r][c] packs to byte 3*r+c, so the array is directly the window format
   logic [2:0][2:0][7:0]  arr_q, arr_d;
   logic [71:0]           window_q, window_d;
   logic                  out_valid_q, out_valid_d;
   logic                  win_last_q, win_last_d;
   logic                  in_ready;
   logic                  accept;
   logic                  col_end;
   logic                  row_end;
   logic                  emit;

   always_comb begin
      in_ready = !start_i && (!out_valid_q || out_ready_i);
      accept   = in_valid_i && in_ready;
      col_end  = (col_q == CW'(IMG_W - 1));
      row_end  = (row_q == RW'(IMG_H - 1));
      emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      arr_d       = arr_q;
      window_d    = window_q;
      out_valid_d = out_valid_q;
      win_last_d  = win_last_q;
      if (start_i) begin
         col_d       = '0;
         row_d       = '0;
         out_valid_d = 1'b0;
         win_last_d  = 1'b0;
      end else begin
         if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               arr_d[r][0] = arr_q[r][1];
               arr_d[r][1] = arr_q[r][2];
            end
            arr_d[0][2] = line2_q[col_q];
            arr_d[1][2] = line1_q[col_q];
            arr_d[2][2] = in_pix_i;
            if (col_end) begin
               col_d = '0;
               row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         // A fresh window overrides the consume-clear in the same cycle
         if (emit) begin
            window_d    = arr_d;
            out_valid_d = 1'b1;
            win_last_d  = row_end && col_end;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q       <= '0;
         row_q       <= '0;
         arr_q       <= '0;
         window_q    <= '0;
         out_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         arr_q       <= arr_d;
         window_q    <= window_d;
         out_valid_q <= out_valid_d;
         win_last_q  <= win_last_d;
      end
   end

   // Line buffers hold no reset; rows 0..1 are rewritten before any window uses them
   always_ff @(posedge clk_i) begin
      if (accept) begin
         line2_q[col_q] <= line1_q[col_q];
         line1_q[col_q] <= in_pix_i;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = out_valid_q;
   assign window_o    = window_q;
   assign win_last_o  = win_last_q;

endmodule

// File: tb/tb_conv_window_builder.sv
// Directed bench for conv_window_builder: a 4x4 instance and a 5x3 instance
// driven on the falling edge and sampled 1 ns later.
module tb_conv_window_builder;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_win_last;
   logic [7:0]  a_in_pix;
   logic [71:0] a_window;
   logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_win_last;
   logic [7:0]  b_in_pix;
   logic [71:0] b_window;

   int          tests_run = 0;
   int          failed    = 0;
   logic [71:0] win_q [$];
   logic        last_q [$];
   logic [71:0] exp4 [4];
   logic [71:0] exp53 [3];

   always #5 clk = ~clk;

   conv_window_builder #(.IMG_W(4), .IMG_H(4)) u_a (
      .clk_i(clk), .rst_i(rst), .start_i(a_start), .in_valid_i(a_in_valid),
      .in_pix_i(a_in_pix), .in_ready_o(a_in_ready), .out_valid_o(a_out_valid),
      .out_ready_i(a_out_ready), .window_o(a_window), .win_last_o(a_win_last));

   conv_window_builder #(.IMG_W(5), .IMG_H(3)) u_b (
      .clk_i(clk), .rst_i(rst), .start_i(b_start), .in_valid_i(b_in_valid),
      .in_pix_i(b_in_pix), .in_ready_o(b_in_ready), .out_valid_o(b_out_valid),
      .out_ready_i(b_out_ready), .window_o(b_window), .win_last_o(b_win_last));

   function automatic bit emit4(int j);
      return (j / 4 >= 2) && (j % 4 >= 2);
   endfunction

   function automatic bit emit53(int j);
      return (j / 5 >= 2) && (j % 5 >= 2);
   endfunction

   // One cycle: drive at the falling edge, sample 1 ns later, log handshakes.
   task automatic step(input bit sel, input bit v, input logic [7:0] p, input bit rdy,
                       input bit st, output logic acc, output logic ov, output logic ir,
                       output logic [71:0] w, output logic lst);
      a_in_valid  = !sel && v;
      a_in_pix    = p;
      a_out_ready = sel ? 1'b1 : rdy;
      a_start     = !sel && st;
      b_in_valid  = sel && v;
      b_in_pix    = p;
      b_out_ready = sel ? rdy : 1'b1;
      b_start     = sel && st;
      #1;
      ov  = sel ? b_out_valid : a_out_valid;
      ir  = sel ? b_in_ready  : a_in_ready;
      w   = sel ? b_window    : a_window;
      lst = sel ? b_win_last  : a_win_last;
      acc = v && ir;
      if (ov === 1'b1 && rdy && !st) begin
         win_q.push_back(w);
         last_q.push_back(lst);
      end
      @(negedge clk);
   endtask

   task automatic run_frames4(input int npix, output int stalls);
      logic acc, ov, ir, lst;
      logic [71:0] w;
      int i = 0;
      int cyc = 0;
      stalls = 0;
      while (i < npix && cyc < npix + 50) begin
         step(0, 1, 8'((i % 16) + 1), 1, 0, acc, ov, ir, w, lst);
         if (acc === 1'b1) i++;
         else stalls++;
         cyc++;
      end
      tests_run++;
      if (i != npix) begin
         failed++;
         $display("FAIL frame_budget: sent %0d pixels, required %0d", i, npix);
      end
      repeat (2) step(0, 0, 8'h00, 1, 0, acc, ov, ir, w, lst);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      tests_run++;
      if ({a_out_valid, a_win_last, a_window, a_in_ready} !== {1'b0, 1'b0, 72'h0, 1'b1}) begin
         failed++;
         $display("FAIL reset_a: ov=%b last=%b win=%h ir=%b, required 0 0 0 1",
                  a_out_valid, a_win_last, a_window, a_in_ready);
      end
      tests_run++;
      if ({b_out_valid, b_win_last, b_window} !== {1'b0, 1'b0, 72'h0}) begin
         failed++;
         $display("FAIL reset_b: ov=%b last=%b win=%h, required 0 0 0",
                  b_out_valid, b_win_last, b_window);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_release: ov=%b ir=%b, required 0 1", a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_basic();
      logic acc, ov, ir, lst;
      logic [71:0] w;
      int k = 0;
      win_q.delete(); last_q.delete();
      for (int i = 0; i <= 16; i++) begin
         step(0, i < 16, 8'(i + 1), 1, 0, acc, ov, ir, w, lst);
         tests_run++;
         if (ov !== ((i > 0) && emit4(i - 1))) begin
            failed++;
            $display("FAIL basic_latency cycle %0d: out_valid=%b, required %b", i, ov,
                     (i > 0) && emit4(i - 1));
         end
         if (i > 0 && emit4(i - 1) && k < 4) begin
            tests_run++;
            if (w !== exp4[k]) begin
               failed++;
               $display("FAIL basic_window %0d: got %h, required %h", k, w, exp4[k]);
            end
            k++;
         end
         if (i < 16) begin
            tests_run++;
            if (acc !== 1'b1) begin
               failed++;
               $display("FAIL basic_accept pixel %0d: in_ready=%b, required 1", i, ir);
            end
         end
      end
      tests_run++;
      if (win_q.size() != 4) begin
         failed++;
         $display("FAIL basic_count: got %0d windows, required 4", win_q.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (win_q[j] !== exp4[j] || last_q[j] !== (j == 3)) begin
               failed++;
               $display("FAIL basic_hs %0d: got %h last=%b, required %h last=%b",
                        j, win_q[j], last_q[j], exp4[j], j == 3);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic acc, ov, ir, lst;
      logic [71:0] w;
      int i = 0;
      int cyc = 0;
      int hold = 0;
      win_q.delete(); last_q.delete();
      while (i < 16 && cyc < 100) begin
         step(0, 1, 8'(i + 1), hold == 0, 0, acc, ov, ir, w, lst);
         if (hold > 0) begin
            tests_run++;
            if (ov !== 1'b1 || w !== exp4[0] || ir !== 1'b0) begin
               failed++;
               $display("FAIL bp_hold: ov=%b win=%h ir=%b, required 1 %h 0", ov, w, ir, exp4[0]);
            end
            hold--;
         end
         if (acc === 1'b1) begin
            if (i == 10) hold = 3;
            i++;
         end
         cyc++;
      end
      tests_run++;
      if (i != 16) begin
         failed++;
         $display("FAIL bp_budget: sent %0d pixels, required 16", i);
      end
      repeat (2) step(0, 0, 8'h00, 1, 0, acc, ov, ir, w, lst);
      tests_run++;
      if (win_q.size() != 4) begin
         failed++;
         $display("FAIL bp_count: got %0d windows, required 4", win_q.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (win_q[j] !== exp4[j] || last_q[j] !== (j == 3)) begin
               failed++;
               $display("FAIL bp_window %0d: got %h last=%b, required %h last=%b",
                        j, win_q[j], last_q[j], exp4[j], j == 3);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int stalls;
      int nlast = 0;
      win_q.delete(); last_q.delete();
      run_frames4(32, stalls);
      tests_run++;
      if (stalls != 0) begin
         failed++;
         $display("FAIL b2b_bubbles: got %0d stalls, required 0", stalls);
      end
      tests_run++;
      if (win_q.size() != 8) begin
         failed++;
         $display("FAIL b2b_count: got %0d windows, required 8", win_q.size());
      end else begin
         for (int j = 0; j < 8; j++) begin
            if (last_q[j] === 1'b1) nlast++;
            tests_run++;
            if (win_q[j] !== exp4[j % 4] || last_q[j] !== (j % 4 == 3)) begin
               failed++;
               $display("FAIL b2b_window %0d: got %h last=%b, required %h last=%b",
                        j, win_q[j], last_q[j], exp4[j % 4], j % 4 == 3);
            end
         end
         tests_run++;
         if (nlast != 2) begin
            failed++;
            $display("FAIL b2b_last_count: got %0d, required 2", nlast);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic acc, ov, ir, lst;
      logic [71:0] w;
      int stalls;
      for (int i = 0; i < 11; i++) step(0, 1, 8'(i + 1), 1, 0, acc, ov, ir, w, lst);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      #1;
      tests_run++;
      if (a_out_valid !== 1'b1) begin
         failed++;
         $display("FAIL rstmid_pre: out_valid=%b, required 1", a_out_valid);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({a_out_valid, a_win_last, a_window} !== {1'b0, 1'b0, 72'h0}) begin
         failed++;
         $display("FAIL rstmid_async: ov=%b last=%b win=%h, required 0 0 0",
                  a_out_valid, a_win_last, a_window);
      end
      @(negedge clk);
      rst = 1'b0;
      win_q.delete(); last_q.delete();
      run_frames4(16, stalls);
      tests_run++;
      if (win_q.size() != 4) begin
         failed++;
         $display("FAIL rstmid_count: got %0d windows, required 4", win_q.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (win_q[j] !== exp4[j] || last_q[j] !== (j == 3)) begin
               failed++;
               $display("FAIL rstmid_window %0d: got %h last=%b, required %h last=%b",
                        j, win_q[j], last_q[j], exp4[j], j == 3);
            end
         end
      end
   endtask

   task automatic test_start();
      logic acc, ov, ir, lst;
      logic [71:0] w;
      int stalls;
      win_q.delete(); last_q.delete();
      for (int i = 0; i < 11; i++) step(0, 1, 8'(i + 1), 1, 0, acc, ov, ir, w, lst);
      step(0, 0, 8'h00, 0, 0, acc, ov, ir, w, lst);
      tests_run++;
      if (ov !== 1'b1 || w !== exp4[0]) begin
         failed++;
         $display("FAIL start_pre: ov=%b win=%h, required 1 %h", ov, w, exp4[0]);
      end
      step(0, 1, 8'h01, 0, 1, acc, ov, ir, w, lst);
      tests_run++;
      if (ir !== 1'b0 || acc !== 1'b0) begin
         failed++;
         $display("FAIL start_in_ready: in_ready=%b accepted=%b, required 0 0", ir, acc);
      end
      step(0, 0, 8'h00, 1, 0, acc, ov, ir, w, lst);
      tests_run++;
      if (ov !== 1'b0 || lst !== 1'b0) begin
         failed++;
         $display("FAIL start_clear: ov=%b last=%b, required 0 0", ov, lst);
      end
      win_q.delete(); last_q.delete();
      run_frames4(16, stalls);
      tests_run++;
      if (win_q.size() != 4) begin
         failed++;
         $display("FAIL start_count: got %0d windows, required 4", win_q.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (win_q[j] !== exp4[j] || last_q[j] !== (j == 3)) begin
               failed++;
               $display("FAIL start_window %0d: got %h last=%b, required %h last=%b",
                        j, win_q[j], last_q[j], exp4[j], j == 3);
            end
         end
      end
   endtask

   task automatic test_width();
      logic acc, ov, ir, lst;
      logic [71:0] w;
      win_q.delete(); last_q.delete();
      for (int i = 0; i <= 15; i++) begin
         step(1, i < 15, 8'(i), 1, 0, acc, ov, ir, w, lst);
         tests_run++;
         if (ov !== ((i > 0) && emit53(i - 1))) begin
            failed++;
            $display("FAIL width_emit cycle %0d: out_valid=%b, required %b", i, ov,
                     (i > 0) && emit53(i - 1));
         end
      end
      step(1, 0, 8'h00, 1, 0, acc, ov, ir, w, lst);
      tests_run++;
      if (win_q.size() != 3) begin
         failed++;
         $display("FAIL width_count: got %0d windows, required 3", win_q.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            tests_run++;
            if (win_q[j] !== exp53[j] || last_q[j] !== (j == 2)) begin
               failed++;
               $display("FAIL width_window %0d: got %h last=%b, required %h last=%b",
                        j, win_q[j], last_q[j], exp53[j], j == 2);
            end
         end
      end
   endtask

   initial begin
      exp4[0]  = 72'h0B0A09070605030201;
      exp4[1]  = 72'h0C0B0A080706040302;
      exp4[2]  = 72'h0F0E0D0B0A09070605;
      exp4[3]  = 72'h100F0E0C0B0A080706;
      exp53[0] = 72'h0C0B0A070605020100;
      exp53[1] = 72'h0D0C0B080706030201;
      exp53[2] = 72'h0E0D0C090807040302;
      a_start = 0; a_in_valid = 0; a_in_pix = 0; a_out_ready = 1;
      b_start = 0; b_in_valid = 0; b_in_pix = 0; b_out_ready = 1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_start();
      test_width();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
